// File: rtl/icache_mshr_alloc_if.sv
// Allocator-facing bundle for the icache MSHR free list: offer/take handshake,
// release/flush return paths and occupancy/error status.
interface icache_mshr_alloc_if #(
    parameter int INDEX_WIDTH = 3
) ();
    logic                   alloc_vld;
    logic [INDEX_WIDTH-1:0] alloc_index;
    logic                   alloc_rdy;
    logic                   release_vld;
    logic [INDEX_WIDTH-1:0] release_index;
    logic                   flush;
    logic [INDEX_WIDTH:0]   free_cnt;
    logic                   full;
    logic                   low_water;
    logic                   err_double_free;
    logic                   err_bad_index;

    // master: the allocator itself; slave: arbiter plus refill/response path
    modport master (
        output alloc_vld, alloc_index, free_cnt, full, low_water,
               err_double_free, err_bad_index,
        input  alloc_rdy, release_vld, release_index, flush
    );

    modport slave (
        input  alloc_vld, alloc_index, free_cnt, full, low_water,
               err_double_free, err_bad_index,
        output alloc_rdy, release_vld, release_index, flush
    );
endinterface

// File: rtl/icache_mshr_alloc.sv
// Free-list allocator for icache MSHR entries: offers the lowest free entry,
// accepts releases and flushes, and tracks occupancy plus sticky protocol errors.
module icache_mshr_alloc #(
    parameter int ENTRY_NUM   = 8,
    parameter int INDEX_WIDTH = $clog2(ENTRY_NUM),
    parameter int LOW_WATER   = 2
) (
    input  logic                clk,
    input  logic                rst,
    icache_mshr_alloc_if.master bus
);
    localparam logic [INDEX_WIDTH:0]   CNT_FULL  = (INDEX_WIDTH+1)'(ENTRY_NUM);
    localparam logic [INDEX_WIDTH:0]   CNT_ONE   = (INDEX_WIDTH+1)'(1);
    localparam logic [INDEX_WIDTH:0]   CNT_LOW   = (INDEX_WIDTH+1)'(LOW_WATER);
    localparam logic [ENTRY_NUM-1:0]   MAP_ONE   = ENTRY_NUM'(1);

    logic [ENTRY_NUM-1:0]   free_q;
    logic [INDEX_WIDTH:0]   free_cnt_q;
    logic                   err_double_free_q;
    logic                   err_bad_index_q;

    logic [ENTRY_NUM-1:0]   alloc_onehot;
    logic [ENTRY_NUM-1:0]   rel_onehot;
    logic                   alloc_vld;
    logic                   alloc_fire;
    logic                   rel_in_range;
    logic                   rel_target_free;
    logic                   release_fire;

    function automatic logic [INDEX_WIDTH-1:0] lowest_free(input logic [ENTRY_NUM-1:0] map);
        logic [INDEX_WIDTH-1:0] idx;
        idx = '0;
        for (int i = ENTRY_NUM - 1; i >= 0; i--) begin
            if (map[i]) idx = INDEX_WIDTH'(i);
        end
        return idx;
    endfunction

    // Clamped at both ends so illegal traffic can never wrap the count.
    function automatic logic [INDEX_WIDTH:0] cnt_next(input logic [INDEX_WIDTH:0] cnt,
                                                      input logic dec,
                                                      input logic inc);
        logic [INDEX_WIDTH:0] r;
        r = cnt;
        if (dec && !inc && cnt != '0)
            r = cnt - CNT_ONE;
        else if (inc && !dec && cnt != CNT_FULL)
            r = cnt + CNT_ONE;
        return r;
    endfunction

    // Offer path depends only on registered state; alloc_rdy never reaches an output.
    assign alloc_vld    = |free_q;
    assign alloc_onehot = free_q & (~free_q + MAP_ONE);
    assign alloc_fire   = alloc_vld & bus.alloc_rdy;

    always_comb begin
        rel_onehot = '0;
        for (int i = 0; i < ENTRY_NUM; i++) begin
            rel_onehot[i] = (bus.release_index == INDEX_WIDTH'(i));
        end
    end

    // An index outside the entry range decodes to no bit at all.
    assign rel_in_range    = |rel_onehot;
    assign rel_target_free = |(rel_onehot & free_q);
    assign release_fire    = bus.release_vld & rel_in_range & ~rel_target_free;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            free_q            <= '1;
            free_cnt_q        <= CNT_FULL;
            err_double_free_q <= 1'b0;
            err_bad_index_q   <= 1'b0;
        end else if (bus.flush) begin
            free_q     <= '1;
            free_cnt_q <= CNT_FULL;
        end else begin
            // Taken and released bits never coincide: a legal release targets a busy entry.
            free_q     <= (free_q & ~(alloc_fire ? alloc_onehot : '0))
                          | (release_fire ? rel_onehot : '0);
            free_cnt_q <= cnt_next(free_cnt_q, alloc_fire, release_fire);
            if (bus.release_vld && !rel_in_range)
                err_bad_index_q <= 1'b1;
            if (bus.release_vld && rel_target_free)
                err_double_free_q <= 1'b1;
        end
    end

    assign bus.alloc_vld       = alloc_vld;
    assign bus.alloc_index     = lowest_free(free_q);
    assign bus.free_cnt        = free_cnt_q;
    assign bus.full            = (free_cnt_q == '0);
    assign bus.low_water       = (free_cnt_q <= CNT_LOW);
    assign bus.err_double_free = err_double_free_q;
    assign bus.err_bad_index   = err_bad_index_q;
endmodule
